// File: rtl/shifter_pkg.sv
// Shared mode and state encodings for the iterative shifter.
package shifter_pkg;

   localparam logic [1:0] SH_PASS = 2'b00;
   localparam logic [1:0] SH_LSL  = 2'b01;
   localparam logic [1:0] SH_LSR  = 2'b10;
   localparam logic [1:0] SH_ASR  = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

endpackage

// File: rtl/iter_shifter_if.sv
// Start/busy/done operand bus between the controller and the iterative shifter.
interface iter_shifter_if #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) ();

   logic             start;
   logic [WIDTH-1:0] in;
   logic [1:0]       shift;
   logic [AMT_W-1:0] amount;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sout;

   modport master (
      output start, in, shift, amount,
      input  busy, done, sout
   );

   modport slave (
      input  start, in, shift, amount,
      output busy, done, sout
   );

endinterface

// File: rtl/shift_step.sv
// Combinational single-position shifter for the four mode encodings.
// ITER_SHIFTER_ROTATE_EN turns the pass mode into rotate-right by one.
module shift_step
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic [WIDTH-1:0] value_i,
   input  logic [1:0]       mode_i,
   output logic [WIDTH-1:0] value_o
);

   always_comb begin
      value_o = value_i;
      case (mode_i)
         SH_PASS: begin
`ifdef ITER_SHIFTER_ROTATE_EN
            value_o = {value_i[0], value_i[WIDTH-1:1]};
`else
            value_o = value_i;
`endif
         end
         SH_LSL:  value_o = {value_i[WIDTH-2:0], 1'b0};
         SH_LSR:  value_o = {1'b0, value_i[WIDTH-1:1]};
         SH_ASR:  value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
         default: value_o = value_i;
      endcase
   end

endmodule

// File: rtl/iter_shifter.sv
// Multi-cycle shifter: one bit position per clock, start/busy/done handshake.
// Optional ITER_SHIFTER_ROTATE_EN (see shift_step) makes mode 00 rotate right.
module iter_shifter
   import shifter_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 4
) (
   input  logic          clk,
   input  logic          reset,
   iter_shifter_if.slave bus
);

   state_e           state_q;
   logic [WIDTH-1:0] work_q;
   logic [AMT_W-1:0] cnt_q;
   logic [1:0]       mode_q;
   logic [WIDTH-1:0] sout_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] step_d;

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .value_i (work_q),
      .mode_i  (mode_q),
      .value_o (step_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         work_q  <= '0;
         cnt_q   <= '0;
         mode_q  <= SH_PASS;
         sout_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  work_q  <= bus.in;
                  cnt_q   <= bus.amount;
                  mode_q  <= bus.shift;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end
            end
            ST_RUN: begin
               // Amounts past WIDTH need no clamp: repeated steps saturate on their own.
               if (cnt_q != '0) begin
                  work_q <= step_d;
                  cnt_q  <= cnt_q - AMT_W'(1);
               end else begin
                  sout_q  <= work_q;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sout = sout_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Scoreboard bench for iter_shifter: expected results queued at issue, popped at done.
module tb_iter_shifter;

   logic clk;
   logic reset;
   int   passed;
   int   total;
   logic [15:0] exp_q[$];

   iter_shifter_if #(.WIDTH(16), .AMT_W(4)) bus ();

   iter_shifter #(
      .WIDTH (16),
      .AMT_W (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: closed-form shifts, independent of the iterative datapath.
   function automatic logic [15:0] model(input logic [15:0] a, input logic [1:0] m, input int n);
      logic [31:0] dbl;
      dbl = {a, a} >> (n % 16);
      case (m)
         2'b01:   return a << n;
         2'b10:   return a >> n;
         2'b11:   return $signed(a) >>> n;
         default: begin
`ifdef ITER_SHIFTER_ROTATE_EN
            return dbl[15:0];
`else
            return a;
`endif
         end
      endcase
   endfunction

   // Issue one op and wait for done; reports latency (-1 on timeout), result, busy history.
   task automatic run_op(input logic [15:0] a, input logic [1:0] m, input logic [3:0] n,
                         output int lat, output logic [15:0] res, output bit busy_ok);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.in     = a;
      bus.shift  = m;
      bus.amount = n;
      exp_q.push_back(model(a, m, int'(n)));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.in    = 16'hDEAD;
      lat       = -1;
      res       = 'x;
      busy_ok   = (bus.busy === 1'b1);
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            res = bus.sout;
            break;
         end
         if (bus.busy !== 1'b1) busy_ok = 0;
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.in    = '0;
      bus.shift = '0;
      bus.amount = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 16'h0000)
         $display("FAIL reset_state got busy=%b done=%b sout=%h want 0 0 0000",
                  bus.busy, bus.done, bus.sout);
      else passed++;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         total++;
         if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 16'h0000)
            $display("FAIL idle_hold cyc%0d got busy=%b done=%b sout=%h want 0 0 0000",
                     i, bus.busy, bus.done, bus.sout);
         else passed++;
      end
   endtask

   task automatic test_lsl();
      int lat;
      logic [15:0] res, exp;
      bit bok;
      run_op(16'h0001, 2'b01, 4'd4, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (lat !== 5) $display("FAIL lsl_latency got %0d want 5", lat); else passed++;
      total++;
      if (res !== exp) $display("FAIL lsl_result got %h want %h", res, exp); else passed++;
      total++;
      if (!bok) $display("FAIL lsl_busy got busy low during run want busy high"); else passed++;
      @(posedge clk);
      #1;
      total++;
      if (bus.done !== 1'b0 || bus.sout !== exp)
         $display("FAIL lsl_hold got done=%b sout=%h want 0 %h", bus.done, bus.sout, exp);
      else passed++;
   endtask

   task automatic test_asr();
      int lat;
      logic [15:0] res, exp;
      bit bok;
      run_op(16'h8000, 2'b11, 4'd15, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 16)
         $display("FAIL asr_sat got %h lat %0d want %h lat 16", res, lat, exp);
      else passed++;
      run_op(16'h002C, 2'b11, 4'd1, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 2)
         $display("FAIL asr_one got %h lat %0d want %h lat 2", res, lat, exp);
      else passed++;
   endtask

   task automatic test_lsr_zero();
      int lat;
      logic [15:0] res, exp;
      bit bok;
      run_op(16'h000C, 2'b10, 4'd1, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 2)
         $display("FAIL lsr_one got %h lat %0d want %h lat 2", res, lat, exp);
      else passed++;
      run_op(16'hFFFF, 2'b10, 4'd15, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp) $display("FAIL lsr_max got %h want %h", res, exp); else passed++;
      run_op(16'h1234, 2'b01, 4'd0, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 1)
         $display("FAIL zero_amount got %h lat %0d want %h lat 1", res, lat, exp);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int lat;
      logic [15:0] exp;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.in     = 16'h00F0;
      bus.shift  = 2'b10;
      bus.amount = 4'd3;
      exp_q.push_back(model(16'h00F0, 2'b10, 3));
      @(posedge clk);
      #1;
      // Stray request while busy must be dropped.
      bus.in     = 16'hFFFF;
      bus.shift  = 2'b01;
      bus.amount = 4'd0;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat = -1;
      for (int i = 2; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      exp = exp_q.pop_front();
      total++;
      if (bus.sout !== exp || lat !== 4)
         $display("FAIL ignore_busy got %h lat %0d want %h lat 4", bus.sout, lat, exp);
      else passed++;
      // Issue the next op in the done cycle.
      bus.start  = 1'b1;
      bus.in     = 16'h0003;
      bus.shift  = 2'b01;
      bus.amount = 4'd2;
      exp_q.push_back(model(16'h0003, 2'b01, 2));
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      total++;
      if (bus.busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", bus.busy);
      else passed++;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) begin
            lat = i;
            break;
         end
      end
      exp = exp_q.pop_front();
      total++;
      if (bus.sout !== exp || lat !== 3)
         $display("FAIL b2b_result got %h lat %0d want %h lat 3", bus.sout, lat, exp);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int seen;
      seen = 0;
      @(negedge clk);
      bus.start  = 1'b1;
      bus.in     = 16'h0001;
      bus.shift  = 2'b01;
      bus.amount = 4'd8;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.sout !== 16'h0000)
         $display("FAIL mid_reset got busy=%b done=%b sout=%h want 0 0 0000",
                  bus.busy, bus.done, bus.sout);
      else passed++;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) seen++;
      end
      total++;
      if (seen !== 0 || bus.busy !== 1'b0 || bus.sout !== 16'h0000)
         $display("FAIL mid_abort got done_pulses=%0d busy=%b sout=%h want 0 0 0000",
                  seen, bus.busy, bus.sout);
      else passed++;
   endtask

   task automatic test_mode00();
      int lat;
      logic [15:0] res, exp;
      bit bok;
      run_op(16'h0001, 2'b00, 4'd1, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 2)
         $display("FAIL mode00_one got %h lat %0d want %h lat 2", res, lat, exp);
      else passed++;
      run_op(16'hA5C3, 2'b00, 4'd5, lat, res, bok);
      exp = exp_q.pop_front();
      total++;
      if (res !== exp || lat !== 6)
         $display("FAIL mode00_five got %h lat %0d want %h lat 6", res, lat, exp);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      test_reset();
      test_lsl();
      test_asr();
      test_lsr_zero();
      test_back_to_back();
      test_reset_mid();
      test_mode00();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
